// File: rtl/servo_pwm_gen_pkg.sv
// rtl/servo_pwm_gen_pkg.sv - shared FSM encoding and default timing for the servo PWM generator
package servo_pwm_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam int DEF_PERIOD_TICKS = 2000;
    localparam int DEF_MIN_POS      = 100;
    localparam int DEF_MAX_POS      = 200;
    localparam int DEF_CENTER_POS   = 150;
    localparam int DEF_STEP         = 1;
    localparam int DEF_CNT_W        = 12;

endpackage

// File: rtl/servo_pwm_gen_tick_sync.sv
// rtl/servo_pwm_gen_tick_sync.sv - synchronise the divider's sclk and turn each rising edge into a one-clk tick
module servo_pwm_gen_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic edge_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= sclk;
            sync2  <= sync1;
            edge_q <= sync2;
        end
    end

    assign tick = sync2 & ~edge_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - tick-framed servo PWM with a saturating position register and per-frame shadow width
import servo_pwm_gen_pkg::*;

module servo_pwm_gen #(
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int MIN_POS      = DEF_MIN_POS,
    parameter int MAX_POS      = DEF_MAX_POS,
    parameter int CENTER_POS   = DEF_CENTER_POS,
    parameter int STEP         = DEF_STEP,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             step_up,
    input  logic             step_dn,
    output logic             pwm_out,
    output logic [CNT_W-1:0] pos,
    output logic             at_min,
    output logic             at_max,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_POS);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_POS);
    localparam logic [CNT_W-1:0] CENTER_C = CNT_W'(CENTER_POS);
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [CNT_W:0]   MAX_X    = (CNT_W+1)'(MAX_POS);
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0]   FLOOR_X  = (CNT_W+1)'(MIN_POS + STEP);

    logic             tick;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] active, active_nxt;
    logic [CNT_W-1:0] pos_nxt;
    logic [CNT_W:0]   pos_x, pos_up;
    logic             pwm_nxt, frame_start_nxt;

    servo_pwm_gen_tick_sync u_tick_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .tick  (tick)
    );

    // Widened by one bit so the upward step cannot wrap before the clamp sees it.
    assign pos_x  = {1'b0, pos};
    assign pos_up = pos_x + STEP_X;

    always_comb begin
        pos_nxt = pos;
        if (step_up && !step_dn) begin
            pos_nxt = (pos_up > MAX_X) ? MAX_C : pos_up[CNT_W-1:0];
        end else if (step_dn && !step_up) begin
            pos_nxt = (pos_x < FLOOR_X) ? MIN_C : (pos - STEP_C);
        end
    end

    assign at_min  = (pos == MIN_C);
    assign at_max  = (pos == MAX_C);
    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        active_nxt      = active;
        pwm_nxt         = pwm_out;
        frame_start_nxt = 1'b0;
        if (tick) begin
            unique case (state)
                S_IDLE: begin
                    cnt_nxt         = '0;
                    active_nxt      = pos;
                    frame_start_nxt = 1'b1;
                    pwm_nxt         = 1'b1;
                    state_nxt       = S_HIGH;
                end
                S_HIGH: begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == active) begin
                        pwm_nxt   = 1'b0;
                        state_nxt = S_LOW;
                    end
                end
                S_LOW: begin
                    if (cnt == LAST_C) begin
                        // Shadow width is only refreshed here, so a pulse in flight never changes.
                        cnt_nxt         = '0;
                        active_nxt      = pos;
                        frame_start_nxt = 1'b1;
                        pwm_nxt         = 1'b1;
                        state_nxt       = S_HIGH;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    pwm_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            active      <= CENTER_C;
            pos         <= CENTER_C;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            active      <= active_nxt;
            pos         <= pos_nxt;
            pwm_out     <= pwm_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - directed table-driven bench for servo_pwm_gen
module tb_servo_pwm_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        step_up = 1'b0;
    logic        step_dn = 1'b0;
    logic        pwm_out;
    logic [11:0] pos;
    logic        at_min;
    logic        at_max;
    logic        frame_start;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        up;
        logic        dn;
        logic [11:0] exp_pos;
        logic        exp_min;
        logic        exp_max;
    } vec_t;

    vec_t vecs [20];

    servo_pwm_gen #(
        .PERIOD_TICKS (20),
        .MIN_POS      (2),
        .MAX_POS      (6),
        .CENTER_POS   (4),
        .STEP         (1),
        .CNT_W        (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .step_up     (step_up),
        .step_dn     (step_dn),
        .pwm_out     (pwm_out),
        .pos         (pos),
        .at_min      (at_min),
        .at_max      (at_max),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One sclk period of 6 clk; DUT outputs are sampled 3 clk after the rise.
    task automatic run_ticks(input int n, output int high_cnt, output int fs_cnt, output logic fs_first);
        high_cnt = 0;
        fs_cnt   = 0;
        fs_first = 1'b0;
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            repeat (3) @(negedge clk);
            if (pwm_out === 1'b1) high_cnt++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (i == 0) fs_first = 1'b1;
            end
            sclk = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic step_pulse(input logic up, input logic dn);
        step_up = up;
        step_dn = dn;
        @(negedge clk);
        step_up = 1'b0;
        step_dn = 1'b0;
    endtask

    initial begin
        int   hc, fc;
        logic ff;

        vecs[0] = '{1'b1, 1'b0, 12'd5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 12'd6, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 12'd6, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 12'd6, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 12'd6, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 12'd5, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 12'd4, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 12'd4, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 12'd4, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 12'd3, 1'b0, 1'b0};
        for (int i = 10; i < 19; i++) vecs[i] = '{1'b0, 1'b1, 12'd2, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 12'd3, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_pos", pos, 4);
        check("reset_pwm", pwm_out, 0);
        check("reset_fs", frame_start, 0);
        check("reset_at_min", at_min, 0);
        check("reset_at_max", at_max, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Position stepping with sclk held low: no ticks, PWM frozen.
        for (int i = 0; i < 20; i++) begin
            step_pulse(vecs[i].up, vecs[i].dn);
            check($sformatf("vec%0d_pos", i), pos, vecs[i].exp_pos);
            check($sformatf("vec%0d_at_min", i), at_min, vecs[i].exp_min);
            check($sformatf("vec%0d_at_max", i), at_max, vecs[i].exp_max);
            check($sformatf("vec%0d_pwm_frozen", i), pwm_out, 0);
            check($sformatf("vec%0d_fs_frozen", i), frame_start, 0);
        end

        rst_n = 1'b0;
        @(negedge clk);
        check("rereset_pos", pos, 4);
        rst_n = 1'b1;
        @(negedge clk);

        // Tick latency: frame_start on the 3rd clk edge after the rise only.
        sclk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("lat_fs_clk%0d", k), frame_start, (k == 3) ? 1 : 0);
            if (k == 3) check("lat_pwm_rise", pwm_out, 1);
        end
        sclk = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("fall_fs_clk%0d", k), frame_start, 0);
        end
        check("fall_pwm_hold", pwm_out, 1);

        run_ticks(19, hc, fc, ff);
        check("f1_rest_high", hc, 3);
        check("f1_rest_fs", fc, 0);

        run_ticks(20, hc, fc, ff);
        check("f2_fs_first", ff, 1);
        check("f2_fs_cnt", fc, 1);
        check("f2_high", hc, 4);

        // Mid-frame step must not disturb the pulse already in progress.
        run_ticks(2, hc, fc, ff);
        check("f3_fs_first", ff, 1);
        check("f3_head_high", hc, 2);
        step_pulse(1'b1, 1'b0);
        check("mid_step_pos", pos, 5);
        run_ticks(18, hc, fc, ff);
        check("f3_tail_high", hc, 2);
        check("f3_tail_fs", fc, 0);

        run_ticks(20, hc, fc, ff);
        check("f4_fs_first", ff, 1);
        check("f4_fs_cnt", fc, 1);
        check("f4_high", hc, 5);

        // Asynchronous reset in the high phase.
        run_ticks(2, hc, fc, ff);
        check("f5_fs_first", ff, 1);
        check("pre_reset_pwm", pwm_out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_pwm", pwm_out, 0);
        check("async_pos", pos, 4);
        check("async_fs", frame_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_ticks(20, hc, fc, ff);
        check("post_fs_first", ff, 1);
        check("post_fs_cnt", fc, 1);
        check("post_high", hc, 4);
        run_ticks(1, hc, fc, ff);
        check("post_next_frame", ff, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream consumer of the slow clock produced by the clock divider.
- Synchronises and edge-detects the divider's sclk output into a one-clk tick.
- Counts ticks to frame a fixed servo period and drives a glitch-free PWM pulse whose width is a saturating position register.
- The tracker control logic nudges the position with step_up/step_dn pulses; pwm_out goes to the servo pin.

Parameters:
PERIOD_TICKS, 2000, ticks per PWM frame (20 ms at 10 us tick)
MIN_POS, 100, minimum pulse width in ticks
MAX_POS, 200, maximum pulse width in ticks
CENTER_POS, 150, reset pulse width in ticks; MIN_POS <= CENTER_POS <= MAX_POS
STEP, 1, ticks added or removed per step request
CNT_W, 12, width of counter and position; 2^CNT_W > PERIOD_TICKS

Ports:
clk  in  1  system clock (same clock that drives the divider)
rst_n  in  1  asynchronous active-low reset
sclk  in  1  divided clock from the divider, treated as a level
step_up  in  1  one-clk pulse: pos += STEP
step_dn  in  1  one-clk pulse: pos -= STEP
pwm_out  out  1  servo PWM, registered
pos  out  CNT_W  pending position (pulse width in ticks)
at_min  out  1  pos == MIN_POS
at_max  out  1  pos == MAX_POS
frame_start  out  1  one-clk pulse when a new frame begins

Behaviour:
- Reset (async, rst_n=0), all registers cleared:
  - sync/edge flops 0, cnt=0, pos=active=CENTER_POS.
  - state=S_IDLE, pwm_out=0, frame_start=0.
- Tick generation:
  - sclk passes a 2-FF synchroniser, then an edge register.
  - tick = sync2 & ~edge_q.
  - tick is asserted for exactly 1 clk, on the 3rd clk edge after sclk rises.
  - Falling edges of sclk are ignored.
- Position register:
  - step_up alone: pos = min(pos+STEP, MAX_POS).
  - step_dn alone: pos = max(pos-STEP, MIN_POS).
  - Both in the same clk: no change.
  - Arithmetic uses CNT_W+1 bits so there is no wrap before saturation.
  - pos updates on the clk after the pulse, independent of tick.
  - at_min/at_max are combinational from pos.
- Shadow register:
  - active is loaded from pos only at frame boundaries.
  - A mid-frame step never alters the current pulse (glitch-free).
- FSM states: S_IDLE, S_HIGH, S_LOW. All transitions are taken only on tick.
  - S_IDLE, first tick after reset:
    - cnt=0, active=pos, frame_start=1.
    - Go to S_HIGH, pwm_out=1.
  - S_HIGH, on tick:
    - cnt+=1.
    - If cnt+1 == active: go to S_LOW, pwm_out=0.
  - S_LOW, on tick:
    - If cnt == PERIOD_TICKS-1: cnt=0, active=pos, frame_start=1, go to S_HIGH, pwm_out=1.
    - Otherwise cnt+=1.
- Resulting waveform: pwm_out is high for exactly active ticks and low for PERIOD_TICKS-active ticks.
- Frame period is exactly PERIOD_TICKS ticks.
- frame_start is high for the single clk of the frame-boundary tick.
- Reset mid-frame: pwm_out drops to 0 immediately (async); a fresh frame begins on the first tick after release.
- sclk held constant: no ticks, all outputs frozen except pos stepping.
- Invariant: active is always within [MIN_POS, MAX_POS] and < PERIOD_TICKS, so S_HIGH always exits before frame end.

Decomposition:
- Shared package holds:
  - FSM state encoding: S_IDLE, S_HIGH, S_LOW, 2 bits.
  - Default timing constants: PERIOD_TICKS, MIN_POS, MAX_POS, CENTER_POS.
- Natural sub-module: tick_sync. It contains the 2-FF synchroniser and rising-edge detector, taking sclk and producing the 1-clk tick.
- Position saturation and FSM stay in servo_pwm_gen.

Test Plan:
- Test parameters: PERIOD_TICKS=20, MIN_POS=2, MAX_POS=6, CENTER_POS=4, STEP=1, sclk toggling every 3 clk.
- Reset release, free-run:
  - First frame_start on the first tick.
  - pwm_out high 4 ticks, low 16 ticks.
  - frame_start every 20 ticks.
- Tick latency: sclk rises -> tick/frame_start asserted on the 3rd clk edge; sclk falls -> no tick.
- Saturation high: 5 step_up pulses from reset -> pos=6, at_max=1; 2 step_dn -> pos=4, at_max=0.
- Simultaneous and floor cases:
  - step_up+step_dn in the same clk -> pos unchanged at 4.
  - 10 step_dn -> pos=2, at_min=1.
- Mid-frame step: step_up at tick 1 of the high phase -> current pulse stays 4 ticks; next frame pulse is 5 ticks.
- Async reset asserted while pwm_out=1 mid-frame:
  - pwm_out=0 and pos=4 immediately.
  - After release, a full 20-tick frame restarts from cnt=0.
